// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared definitions for the nibble-serial adder sequencer.
//   NIB_W   - width of one nibble slice handed to the external adder
//   state_e - sequencer states
//   nnib()  - number of nibble slices in an operand of the given width
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int nnib(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter.
//   clk, rst_n - clock and synchronous active-low reset
//   req[1:0]   - request lines
//   adv        - the current grant was taken; remember it for fairness
//   gnt[1:0]   - one-hot grant (all zero when nothing is requested)
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2
  import nibble_add_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned (which would infer a latch).
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (adv) begin
      last_grant_d = gnt[1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/nibble_add_sched.sv
// nibble_add_sched: shares one external 4-bit ripple adder between two
// requesters. Each accepted WIDTH-bit add is fed to the adder one nibble per
// cycle, LSB first, with the carry chained through carry_q; the assembled sum
// is returned on a valid/ready response port tagged with the requester id.
//   req0_*/req1_*  - request ports (valid/ready, operands a/b, carry-in ci)
//   rsp_*          - response port (valid/ready, sum, carry-out co, id)
//   add_a/add_b/add_ci -> external adder inputs (zero outside RUN)
//   add_sum/add_co     <- external adder outputs
module nibble_add_sched
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic             rsp_id,
  output logic [NIB_W-1:0] add_a,
  output logic [NIB_W-1:0] add_b,
  output logic             add_ci,
  input  logic [NIB_W-1:0] add_sum,
  input  logic             add_co
);

  localparam int NNIB  = nnib(WIDTH);
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
    $error("nibble_add_sched: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_co_q, rsp_co_d;
  logic             rsp_id_q, rsp_id_d;

  logic [1:0] gnt;
  logic       accept;

  // Arbiter only advances on a real accept, so a grant offered while the
  // requester drops valid does not disturb the round-robin order.
  assign accept = (state_q == IDLE) && (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({req1_valid, req0_valid}),
    .adv  (accept),
    .gnt  (gnt)
  );

  assign req0_ready = (state_q == IDLE) && gnt[0];
  assign req1_ready = (state_q == IDLE) && gnt[1];

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co    = rsp_co_q;
  assign rsp_id    = rsp_id_q;

  // Adder inputs are forced to zero outside RUN to keep the shared adder quiet.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = opa_q[NIB_W*idx_q +: NIB_W];
      add_b  = opb_q[NIB_W*idx_q +: NIB_W];
      add_ci = carry_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    id_d      = id_q;
    rsp_sum_d = rsp_sum_q;
    rsp_co_d  = rsp_co_q;
    rsp_id_d  = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = gnt[1] ? req1_a  : req0_a;
          opb_d   = gnt[1] ? req1_b  : req0_b;
          carry_d = gnt[1] ? req1_ci : req0_ci;
          id_d    = gnt[1];
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[NIB_W*idx_q +: NIB_W] = add_sum;
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          // Response registers load only here, so they hold the previous
          // result while the next operation is being assembled in res_q.
          rsp_sum_d = res_d;
          rsp_co_d  = add_co;
          rsp_id_d  = id_q;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      rsp_sum_q <= '0;
      rsp_co_q  <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_co_q  <= rsp_co_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // NOTE: operand/result/id registers carry no reset: they are always written
  // (handshake or RUN) before anything downstream reads them.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    res_q <= res_d;
    id_q  <= id_d;
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: drives nibble_add_sched (WIDTH=16) with an attached
// ripple-adder model, checks every cycle against a transaction-level model,
// and pins that model with hand-computed directed scenarios.
module tb_nibble_add_sched;

  localparam int WIDTH = 16;
  localparam int NNIB  = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ci, req1_ci;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_co, rsp_id;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_ci, add_co;

  int n_tests = 0;
  int n_fail  = 0;
  logic ci_seq [0:63];

  always #5 clk = ~clk;

  // External 4-bit ripple adder, purely combinational.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

  nibble_add_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ci   (req0_ci),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ci   (req1_ci),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
    .rsp_id    (rsp_id),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_sum   (add_sum),
    .add_co    (add_co)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner among valid requesters: a tie goes to the one not granted last.
  function automatic int grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Carry entering nibble i of a+b+ci.
  function automatic longint unsigned carry_into(input logic [15:0] a, input logic [15:0] b,
                                                 input logic ci, input int i);
    longint unsigned m;
    m = (64'd1 << (4 * i)) - 64'd1;
    return ((a & m) + (b & m) + ci) >> (4 * i);
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Transaction-level model: an accepted op occupies NNIB adder cycles, then
  // offers its result until taken; response fields hold between results.
  initial begin : compare
    logic busy, last, cci, cid, m_co, m_id;
    int cnt, g, i;
    logic [15:0] ca, cb, m_sum;
    logic [3:0] ea, eb;
    logic eci;
    longint unsigned full;
    busy = 0; last = 1; cnt = 0; ca = 0; cb = 0; cci = 0; cid = 0;
    m_sum = 0; m_co = 0; m_id = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = grant(req0_valid, req1_valid, last);
      check("req0_ready", req0_ready, !busy && g == 0);
      check("req1_ready", req1_ready, !busy && g == 1);
      check("rsp_valid", rsp_valid, busy && cnt > NNIB);
      check("rsp_sum", rsp_sum, m_sum);
      check("rsp_co", rsp_co, m_co);
      check("rsp_id", rsp_id, m_id);
      ea = 0; eb = 0; eci = 0;
      if (busy && cnt <= NNIB) begin
        i   = cnt - 1;
        ea  = 4'(ca >> (4 * i));
        eb  = 4'(cb >> (4 * i));
        eci = carry_into(ca, cb, cci, i) != 0;
      end
      check("add_a", add_a, ea);
      check("add_b", add_b, eb);
      check("add_ci", add_ci, eci);
      if (!rst_n) begin
        busy = 0; last = 1; m_sum = 0; m_co = 0; m_id = 0;
      end else if (!busy) begin
        if (g >= 0) begin
          busy = 1; cnt = 1;
          ca  = (g == 1) ? req1_a  : req0_a;
          cb  = (g == 1) ? req1_b  : req0_b;
          cci = (g == 1) ? req1_ci : req0_ci;
          cid = (g == 1);
          last = cid;
        end
      end else if (cnt <= NNIB) begin
        cnt++;
        if (cnt == NNIB + 1) begin
          full  = 64'(ca) + 64'(cb) + 64'(cci);
          m_sum = full[15:0];
          m_co  = full[16];
          m_id  = cid;
        end
      end else if (rsp_ready) begin
        busy = 0;
      end
    end
  end

  // Present an op on one requester until accepted, then withdraw it.
  task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic ci);
    logic ok, hit;
    ok = 0;
    if (id) begin req1_a = a; req1_b = b; req1_ci = ci; req1_valid = 1; end
    else    begin req0_a = a; req0_b = b; req0_ci = ci; req0_valid = 1; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      hit = id ? req1_ready : req0_ready;
      @(posedge clk); #1;
      if (hit) begin
        ok = 1;
        if (id) req1_valid = 0; else req0_valid = 0;
        break;
      end
    end
    check("issue_accepted", ok, 1);
  endtask

  // Wait (rsp_ready high) for the response; lat counts cycles after accept.
  task automatic wait_rsp(output logic [15:0] s, output logic co, output logic rid,
                          output int lat);
    logic found;
    found = 0; s = 0; co = 0; rid = 0; lat = 0;
    rsp_ready = 1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      ci_seq[k] = add_ci;
      if (rsp_valid) begin
        s = rsp_sum; co = rsp_co; rid = rsp_id; lat = k; found = 1;
      end
      @(posedge clk); #1;
      if (found) break;
    end
    check("rsp_arrived", found, 1);
  endtask

  initial begin : stim
    logic [15:0] s;
    logic co, rid, drop;
    int lat, n_acc, n_rsp;
    int acc_cyc [0:3];
    logic rsp_ids [0:3];
    logic [15:0] rsp_sums [0:3];

    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ci = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ci = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_add_a", add_a, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Carry ripple through every nibble.
    issue(0, 16'hFFFF, 16'h0001, 0);
    wait_rsp(s, co, rid, lat);
    check("ripple_sum", s, 16'h0000);
    check("ripple_co", co, 1);
    check("ripple_id", rid, 0);
    check("ripple_latency", lat, NNIB + 1);
    check("ripple_ci_seq", {ci_seq[1], ci_seq[2], ci_seq[3], ci_seq[4]}, 4'b0111);

    // Carry-in, no overflow.
    issue(1, 16'h1234, 16'h4321, 1);
    wait_rsp(s, co, rid, lat);
    check("cin_sum", s, 16'h5556);
    check("cin_co", co, 0);
    check("cin_id", rid, 1);

    // Tie arbitration with both requesters held valid.
    req0_a = 16'h0001; req0_b = 16'h0001; req0_ci = 0;
    req1_a = 16'h0002; req1_b = 16'h0002; req1_ci = 0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    n_acc = 0; n_rsp = 0; drop = 0;
    for (int k = 0; k < 80 && n_rsp < 4; k++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (n_acc < 4) acc_cyc[n_acc] = k;
        n_acc++;
        if (n_acc == 4) drop = 1;
      end
      if (rsp_valid && rsp_ready) begin
        if (n_rsp < 4) begin rsp_ids[n_rsp] = rsp_id; rsp_sums[n_rsp] = rsp_sum; end
        n_rsp++;
      end
      @(posedge clk); #1;
      if (drop) begin req0_valid = 0; req1_valid = 0; end
    end
    check("tie_rsp_count", n_rsp, 4);
    check("tie_acc_count", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      check("tie_id", rsp_ids[i], i % 2);
      check("tie_sum", rsp_sums[i], (i % 2) ? 16'h0004 : 16'h0002);
    end
    for (int i = 0; i < 3; i++) check("tie_spacing", acc_cyc[i+1] - acc_cyc[i], NNIB + 2);

    // Backpressure in DONE with a competing request pending.
    rsp_ready = 0;
    issue(0, 16'h8000, 16'h8000, 1);
    req1_a = 16'h0005; req1_b = 16'h0006; req1_ci = 0; req1_valid = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_sum", rsp_sum, 16'h0001);
      check("stall_co", rsp_co, 1);
      check("stall_ready", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1; rsp_ready = 1;
    @(negedge clk);
    check("pulse_valid", rsp_valid, 1);
    @(posedge clk); #1; rsp_ready = 0;
    @(negedge clk);
    check("after_pulse_valid", rsp_valid, 0);
    check("after_pulse_idle", req1_ready, 1);
    @(posedge clk); #1; req1_valid = 0;
    wait_rsp(s, co, rid, lat);
    check("bp_next_sum", s, 16'h000B);
    check("bp_next_id", rid, 1);

    // Reset while RUN is on nibble 2.
    issue(0, 16'h0F0F, 16'h0101, 0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_sum", rsp_sum, 0);
    check("rst_mid_add", {add_a, add_b, add_ci}, 9'd0);
    @(posedge clk); #1;
    req0_a = 16'h0003; req0_b = 16'h0004; req0_ci = 0;
    req1_a = 16'h0009; req1_b = 16'h0009; req1_ci = 0;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("rst_tie_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
    wait_rsp(s, co, rid, lat);
    check("rst_after_sum", s, 16'h0007);
    check("rst_after_id", rid, 0);

    // Randomised traffic, backpressure and occasional resets.
    for (int c = 0; c < 800; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = rnd_op(); req0_b = rnd_op(); req0_ci = 1'($urandom);
      req1_a = rnd_op(); req1_b = rnd_op(); req1_ci = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1; rst_n = 1;
    repeat (NNIB + 4) begin
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
- Nibble-serial sequencer and 2-way arbiter that shares one external 4-bit ripple_adder (co, SUM[3:0], A[3:0], B[3:0], ci) between two requesters.
- Each request is a WIDTH-bit add with carry-in. The block feeds the adder one nibble per cycle, LSB first, and chains the carry through an internal register.
- It assembles the WIDTH-bit sum and returns it on a valid/ready response port tagged with the requester id.
- The adder instance sits beside this block in the parent; there is no combinational feedback other than adder inputs to adder outputs.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_ci  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_ci  same directions and widths as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  WIDTH  sum
- rsp_co  output  1  final carry-out
- rsp_id  output  1  requester that issued the result
- add_a  output  4  to adder A
- add_b  output  4  to adder B
- add_ci  output  1  to adder ci
- add_sum  input  4  from adder SUM
- add_co  input  1  from adder co

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: state=IDLE, idx=0, carry=0, last_grant=1 (so req0 wins the first tie). Outputs: rsp_valid=0, rsp_sum=0, rsp_co=0, rsp_id=0.
- NNIB = WIDTH/4.

State IDLE:
- reqX_ready is combinational: reqX_ready = (state==IDLE) && grant==X.
- Grant rule: if only one requester is valid, grant it. If both are valid, grant the requester that is not last_grant.
- At most one ready is high per cycle. ready never depends on rsp_ready.
- On a handshake, latch opa, opb, carry<=ci, id<=grant, last_grant<=grant, idx<=0, then go to RUN.

State RUN:
- add_a=opa[4*idx+:4], add_b=opb[4*idx+:4], add_ci=carry.
- Each cycle: res[4*idx+:4]<=add_sum, carry<=add_co.
- If idx==NNIB-1, go to DONE; otherwise idx<=idx+1.
- The adder is treated as purely combinational within the cycle.

State DONE:
- rsp_valid=1; rsp_sum=res, rsp_co=carry, rsp_id=id. All are stable until the rsp_ready handshake.
- On handshake, go to IDLE. No new request is accepted in the handshake cycle.

Adder-port and response holding:
- Outside RUN, add_a=0, add_b=0, add_ci=0, which keeps adder toggling quiet.
- After a response is accepted, rsp_sum, rsp_co and rsp_id hold their last values; rsp_valid drops to 0.

Timing:
- Latency: request accepted at cycle T; RUN occupies T+1..T+NNIB; rsp_valid rises at T+NNIB+1.
- With rsp_ready held high, a new accept can occur at T+NNIB+2, giving one operation per NNIB+2 cycles.

Arithmetic:
- Results are modulo 2^WIDTH; rsp_co = carry out of bit WIDTH-1.
- With WIDTH=4, exactly one RUN cycle is used.

Boundary conditions:
- Backpressure: rsp_ready low in DONE stalls indefinitely. Requesters see ready=0 for the whole stall; no starvation accounting beyond round-robin.
- A requester dropping valid before ready is legal. Operands are only sampled in the handshake cycle.
- Reset mid-RUN or mid-DONE: the operation is discarded, no response is issued, and last_grant returns to 1.

Decomposition:
- Package nibble_add_pkg:
  - NIB_W=4
  - state enum {IDLE, RUN, DONE}
  - function nnib(width) returning width/NIB_W
- Sub-module rr_arb2: 2-request round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], adv.
  - Output: one-hot gnt[1:0].
  - Internal last_grant register, reset value 1, updated on adv.
- Sequencer datapath (operand registers, result register, idx, carry) stays in nibble_add_sched.

Test Plan:
All scenarios use WIDTH=16 with a real ripple_adder connected.
- Carry ripple: req0 a=0xFFFF b=0x0001 ci=0, rsp_ready=1 -> rsp_valid at T+5 with sum=0x0000, co=1, id=0; add_ci sequence during RUN is 0,1,1,1.
- Carry-in and no overflow: req1 a=0x1234 b=0x4321 ci=1 -> sum=0x5556, co=0, id=1.
- Tie arbitration: req0 and req1 both valid continuously, each holding an op (0x0001+0x0001 and 0x0002+0x0002) -> responses alternate id 0,1,0,1 with sums 0x0002/0x0004; accepts every 6 cycles.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_sum stable, both reqX_ready=0 throughout; the single-cycle rsp_ready pulse returns the block to IDLE the next cycle.
- Reset mid-operation: assert rst_n=0 during RUN idx=2 for 1 cycle -> next cycle IDLE, rsp_valid=0, add_a/add_b/add_ci=0; a following request completes correctly with req0 winning a tie.
